sync_down_counter: RTL

Synchronous modulo-N down counter: the count-down companion to the team's JK-based up counter, for timeout, delay and countdown functions. Each bit is a JK flip-flop whose J and K inputs are derived combinationally from the lower bits. The block supports parallel load, count enable, a zero flag and a registered borrow pulse on wrap-around. It sits beside the up counter in the lab datapath and drives downstream sequencing logic.

---
 rtl/sync_down_counter.sv | 76 +++++++
 1 files changed

// File: rtl/sync_down_counter.sv
// Modulo-MODULUS down counter built from per-bit JK flip-flops with parallel load,
// count enable, a combinational zero flag and a registered borrow pulse on wrap.
module sync_down_counter #(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned MODULUS = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             zero,
  output logic             borrow
);

  localparam logic [WIDTH-1:0] MaxVal  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   ModWide = (WIDTH + 1)'(MODULUS);
  localparam bit               PowTwo  = ((MODULUS & (MODULUS - 1)) == 0);

  if (WIDTH < 2 || WIDTH > 8) begin : g_bad_width
    $error("sync_down_counter: WIDTH must be in 2..8");
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("sync_down_counter: MODULUS must be in 2..2**WIDTH");
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] j, k;
  logic [WIDTH-1:0] load_clamped;
  logic             borrow_q, borrow_d;
  logic             q_is_zero;
  logic             lower_zero;

  assign q_is_zero    = (q_q == '0);
  assign load_clamped = ({1'b0, load_val} < ModWide) ? load_val : MaxVal;

  always_comb begin
    j          = '0;
    k          = '0;
    lower_zero = 1'b1;
    if (load) begin
      j = load_clamped;
      k = ~load_clamped;
    end else if (en) begin
      if (q_is_zero && !PowTwo) begin
        // Non power-of-two wrap: steer every bit straight to MODULUS-1.
        j = MaxVal;
        k = ~MaxVal;
      end else begin
        for (int i = 0; i < int'(WIDTH); i++) begin
          j[i]       = lower_zero;
          k[i]       = lower_zero;
          lower_zero = lower_zero & ~q_q[i];
        end
      end
    end
    q_d      = (j & ~q_q) | (~k & q_q);
    borrow_d = en & ~load & q_is_zero;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      q_q      <= '0;
      borrow_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      borrow_q <= borrow_d;
    end
  end

  assign Q      = q_q;
  assign zero   = q_is_zero;
  assign borrow = borrow_q;

endmodule
